uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART sender between NREQ requesters. Captures one DATA_W-bit word from the granted requester and drives the sender's flag/data inputs for exactly one frame window. Enforces an idle gap between frames. The sender has no busy output, so frame timing is counted locally in clk cycles.

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART sender among NREQ
// requesters. Captures the granted requester's word, holds tx_flag/tx_data for
// FRAME_CLKS cycles, then enforces GAP_CLKS idle cycles before re-arbitrating.
// Optional macro UART_TX_ARB_FRAME_CNT_EN adds a 16-bit completed-frame counter.
`timescale 1ns/1ps

module uart_tx_arbiter #(
   parameter int NREQ       = 4,
   parameter int DATA_W     = 7,
   parameter int FRAME_CLKS = 10,
   parameter int GAP_CLKS   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          grant,
   output logic                     tx_flag,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  cur_id
`ifdef UART_TX_ARB_FRAME_CNT_EN
   ,
   output logic [15:0]              frame_cnt
`endif
);

   localparam int ID_W     = $clog2(NREQ);
   localparam int MAX_CLKS = (FRAME_CLKS > GAP_CLKS) ? FRAME_CLKS : GAP_CLKS;
   localparam int CNT_W    = $clog2(MAX_CLKS + 1);

   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CLKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t             state, state_nxt;
   logic [ID_W-1:0]    ptr, ptr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [NREQ-1:0]    grant_nxt;
   logic               flag_nxt;
   logic [DATA_W-1:0]  data_nxt;
   logic [ID_W-1:0]    id_nxt;
   logic               win_found;
   logic [ID_W-1:0]    win_id;

   // Requester index 'off' positions after 'base', wrapping at NREQ.
   function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
      return ID_W'((base + off) % NREQ);
   endfunction

   // Round-robin search: first asserted request starting just after the last winner.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!win_found && req[wrap_idx(int'(ptr), i)]) begin
            win_found = 1'b1;
            win_id    = wrap_idx(int'(ptr), i);
         end
      end
   end

   // Next-state and next-output logic for the IDLE/SEND/GAP sequence.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      grant_nxt = '0;
      flag_nxt  = tx_flag;
      data_nxt  = tx_data;
      id_nxt    = cur_id;
      unique case (state)
         IDLE: begin
            flag_nxt = 1'b0;
            if (win_found) begin
               state_nxt         = SEND;
               grant_nxt[win_id] = 1'b1;
               data_nxt          = req_data[win_id*DATA_W +: DATA_W];
               flag_nxt          = 1'b1;
               id_nxt            = win_id;
               ptr_nxt           = win_id;
               cnt_nxt           = '0;
            end
         end
         SEND: begin
            if (cnt == FRAME_LAST) begin
               flag_nxt  = 1'b0;
               cnt_nxt   = '0;
               state_nxt = (GAP_CLKS > 0) ? GAP : IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; reset clears the sender flag immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= ID_W'(NREQ - 1);
         cnt     <= '0;
         grant   <= '0;
         tx_flag <= 1'b0;
         tx_data <= '0;
         cur_id  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         cnt     <= cnt_nxt;
         grant   <= grant_nxt;
         tx_flag <= flag_nxt;
         tx_data <= data_nxt;
         cur_id  <= id_nxt;
      end
   end

   assign busy = (state != IDLE);

`ifdef UART_TX_ARB_FRAME_CNT_EN
   logic frame_done;
   assign frame_done = (state == SEND) && (cnt == FRAME_LAST);

   // Count frames that ran to completion; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_cnt <= '0;
      else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
   end
`endif

endmodule
